// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int FETCH_DW   = 64;
  localparam int FETCH_STEP = 8;

  typedef struct packed {
    logic [FETCH_DW-1:0] addr;
    logic [FETCH_DW-1:0] data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_e;

  function automatic logic [FETCH_DW-1:0] align_dw(input logic [FETCH_DW-1:0] a);
    return {a[FETCH_DW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered in-order FIFO of fetched {address, data} doublewords.
// The head reads as all-zero while the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] usage
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign usage   = count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity comes only from count,
  // so clearing the array would buy nothing but reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential doubleword fetch front-end with credit-based request issue,
// flush/redirect and halt. Define FETCH_PERF_EN to build the stall counter.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [63:0] BOOT_ADDR = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [63:0] flush_pc_i,
  input  logic        halt_i,
  output logic [63:0] instr_if_address_o,
  output logic        instr_if_data_req_o,
  input  logic        instr_if_data_gnt_i,
  input  logic        instr_if_data_rvalid_i,
  input  logic [63:0] instr_if_data_rdata_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_addr_o,
  output logic [63:0] fetch_rdata_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_stall_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state, state_next;
  logic [63:0]   pc, rsp_pc;
  logic [CW-1:0] occ, outst, disc, outst_next, credit;
  logic          req, fire, rsp_ok, rsp_drop, push, pop, full, empty;
  fetch_entry_t  head;

  // Space still free once every live in-flight response has landed.
  assign credit     = CW'(DEPTH) - occ - (outst - disc);
  assign fire       = req & instr_if_data_gnt_i;
  assign rsp_ok     = instr_if_data_rvalid_i & (outst != '0);
  assign rsp_drop   = rsp_ok & (disc != '0);
  assign push       = rsp_ok & ~rsp_drop & ~flush_i;
  assign pop        = ~empty & fetch_ready_i;
  assign outst_next = outst + CW'(fire) - CW'(rsp_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= BOOT;
    else         state <= state_next;
  end

  // NOTE: every always_comb output gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    // BOOT, RUN and HALTED all resolve the same way, flush included.
    state_next = halt_i ? HALTED : RUN;
    req        = (state == RUN) & ~halt_i & ~flush_i & (credit != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc     <= align_dw(BOOT_ADDR);
      rsp_pc <= align_dw(BOOT_ADDR);
      outst  <= '0;
      disc   <= '0;
    end else begin
      outst <= outst_next;
      if (flush_i) begin
        pc     <= align_dw(flush_pc_i);
        rsp_pc <= align_dw(flush_pc_i);
        disc   <= outst_next;
      end else begin
        if (state == BOOT) begin
          pc     <= align_dw(BOOT_ADDR);
          rsp_pc <= align_dw(BOOT_ADDR);
        end else begin
          if (fire) pc     <= pc + 64'(FETCH_STEP);
          if (push) rsp_pc <= rsp_pc + 64'(FETCH_STEP);
        end
        if (rsp_drop) disc <= disc - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .flush  (flush_i),
    .wdata  ('{addr: rsp_pc, data: instr_if_data_rdata_i}),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .usage  (occ)
  );

  assign instr_if_address_o  = pc;
  assign instr_if_data_req_o = req;
  assign fetch_valid_o       = ~empty;
  assign fetch_addr_o        = head.addr;
  assign fetch_rdata_o       = head.data;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && !halt_i && empty && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_stall_cnt_o = stall_cnt;
`else
  assign fetch_stall_cnt_o = '0;
`endif

  rvalid_without_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_if_data_rvalid_i && (outst == '0)));

  // The credit scheme guarantees a full FIFO is never pushed without a pop.
  no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed phases plus a random
// phase, all compared against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [63:0] BOOT  = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, halt, gnt, rvalid, ready;
  logic [63:0] flush_pc, rdata;
  logic        req, fvalid;
  logic [63:0] addr_o, faddr, fdata;
  logic [31:0] stall;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .flush_i                (flush),
    .flush_pc_i             (flush_pc),
    .halt_i                 (halt),
    .instr_if_address_o     (addr_o),
    .instr_if_data_req_o    (req),
    .instr_if_data_gnt_i    (gnt),
    .instr_if_data_rvalid_i (rvalid),
    .instr_if_data_rdata_i  (rdata),
    .fetch_valid_o          (fvalid),
    .fetch_addr_o           (faddr),
    .fetch_rdata_o          (fdata),
    .fetch_ready_i          (ready),
    .fetch_stall_cnt_o      (stall)
  );

  typedef struct {
    logic [63:0] addr;
    int          gcyc;
    bit          live;
  } txn_t;

  txn_t        inflight[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          grants = 0;
  int          first_valid = -1;
  int          p_gnt, p_rsp, p_ready, p_flush, p_halt;
  bit          force_flush = 0;
  logic [63:0] force_tgt = '0;

  // Reference model: where the stream stands, not how the RTL counts it.
  bit          m_run;
  int          buffered;
  logic [63:0] m_req_pc, m_head;
  int          m_stall;

  function automatic logic [63:0] memf(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_1234_5678_9ABC;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 0; halt = 0; gnt = 0; rvalid = 0; ready = 0;
    flush_pc = '0; rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", 64'(req), 64'd0);
    check("rst_addr", addr_o, BOOT);
    check("rst_valid", 64'(fvalid), 64'd0);
    check("rst_faddr", faddr, 64'd0);
    check("rst_fdata", fdata, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    inflight.delete();
    m_run = 0; buffered = 0; m_req_pc = BOOT; m_head = BOOT; m_stall = 0;
    cyc = 1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle; entered right after a falling edge.
  task automatic step();
    int   live_n;
    bit   exp_req, pop_m;
    txn_t t;
    flush    = force_flush || ($urandom_range(99) < p_flush);
    flush_pc = force_flush ? force_tgt : {$urandom, $urandom};
    force_flush = 0;
    halt  = $urandom_range(99) < p_halt;
    gnt   = $urandom_range(99) < p_gnt;
    ready = $urandom_range(99) < p_ready;
    if (inflight.size() > 0 && inflight[0].gcyc < cyc && $urandom_range(99) < p_rsp) begin
      rvalid = 1'b1;
      rdata  = memf(inflight[0].addr);
    end else begin
      rvalid = 1'b0;
      rdata  = {$urandom, $urandom};
    end
    #1;
    live_n = 0;
    foreach (inflight[i]) if (inflight[i].live) live_n++;
    exp_req = m_run && !halt && !flush && (live_n + buffered < DEPTH);
    check("req", 64'(req), 64'(exp_req));
    if (exp_req) check("req_addr", addr_o, m_req_pc);
    check("valid", 64'(fvalid), 64'(buffered > 0));
    if (buffered > 0) begin
      check("head_addr", faddr, m_head);
      check("head_data", fdata, memf(m_head));
    end
    check("stall_cnt", 64'(stall), 64'(m_stall));
    if (fvalid && first_valid < 0) first_valid = cyc;
    if (req && gnt && !flush) begin
      grants++;
      req_log.push_back(addr_o);
    end
    pop_m = (buffered > 0) && ready && !flush;
    if (pop_m) pop_log.push_back(faddr);
    @(posedge clk);
`ifdef FETCH_PERF_EN
    if (m_run && !halt && buffered == 0) m_stall++;
`endif
    if (rvalid) begin
      t = inflight.pop_front();
      if (t.live && !flush) buffered++;
    end
    if (flush) begin
      foreach (inflight[i]) inflight[i].live = 0;
      buffered = 0;
      m_req_pc = {flush_pc[63:3], 3'b000};
      m_head   = {flush_pc[63:3], 3'b000};
    end else begin
      if (req && gnt) begin
        t.addr = m_req_pc; t.gcyc = cyc; t.live = 1;
        inflight.push_back(t);
        m_req_pc += 64'd8;
      end
      if (pop_m) begin
        buffered--;
        m_head += 64'd8;
      end
    end
    m_run = !halt;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Full-rate streaming with a 1-cycle memory and an always-ready consumer.
    p_gnt = 100; p_rsp = 100; p_ready = 100; p_flush = 0; p_halt = 0;
    grants = 0;
    repeat (20) step();
    check("first_valid_cycle", 64'(first_valid), 64'd4);
    check("stream_grants", 64'(grants), 64'd19);

    // Redirect to 0x1004 with one response in flight, then stall the consumer.
    p_ready = 0; p_rsp = 0;
    force_flush = 1; force_tgt = 64'h1004;
    req_log.delete(); pop_log.delete();
    step();
    p_rsp = 100; grants = 0;
    repeat (12) step();
    check("backpressure_grants", 64'(grants), 64'(DEPTH));
    check("flush_req_cnt", 64'(req_log.size() >= 1), 64'd1);
    if (req_log.size() >= 1) check("flush_first_req", req_log[0], 64'h1000);
    p_ready = 100;
    repeat (12) step();
    check("flush_pop_cnt", 64'(pop_log.size() >= 2), 64'd1);
    if (pop_log.size() >= 2) begin
      check("flush_first_pop", pop_log[0], 64'h1000);
      check("flush_second_pop", pop_log[1], 64'h1008);
    end

    // Halt for five cycles while the buffer drains.
    grants = 0; p_halt = 100;
    repeat (5) step();
    check("halt_grants", 64'(grants), 64'd0);
    p_halt = 0;
    repeat (6) step();

    // Address wrap-around at 2^64.
    req_log.delete();
    force_flush = 1; force_tgt = 64'hFFFF_FFFF_FFFF_FFFB;
    repeat (4) step();
    check("wrap_req_cnt", 64'(req_log.size() >= 2), 64'd1);
    if (req_log.size() >= 2) begin
      check("wrap_first", req_log[0], 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap_second", req_log[1], 64'h0);
    end

    // Random traffic: stalling grants, variable latency, flushes, halts.
    p_gnt = 70; p_rsp = 60; p_ready = 60; p_flush = 3; p_halt = 10;
    repeat (3000) step();

    // Drain everything still in flight or buffered.
    p_gnt = 0; p_rsp = 100; p_ready = 100; p_flush = 0; p_halt = 0;
    repeat (20) step();
    check("drain_inflight", 64'(inflight.size()), 64'd0);
    check("drain_valid", 64'(fvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
